// File: rtl/if_fetch_pkg.sv
// Shared types and sizing constants for the IF fetch sequencer and its
// tagged output buffer.
package if_fetch_pkg;

    localparam int NUM_TRD   = 8;
    localparam int TRD_W     = 3;
    localparam int PC_W      = 32;
    localparam int INST_W    = 32;
    localparam int BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [TRD_W-1:0]  trd;
        logic              vld;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buf.sv
// Tagged instruction FIFO feeding IF/ID. Entries of a killed thread are
// invalidated in place and skipped silently when they reach the head.
module if_fetch_buf
    import if_fetch_pkg::*;
#(
    parameter int DEPTH = BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [PC_W-1:0]   push_pc,
    input  logic [TRD_W-1:0]  push_trd,
    input  logic              kill_vld,
    input  logic [TRD_W-1:0]  kill_trd,
    input  logic              id_rdy,
    output logic              if_vld,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic [TRD_W-1:0]  if_trd,
    output logic              buf_free
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    fetch_entry_t     head;
    logic             present;
    logic             pop;

    assign head     = mem[rd_ptr];
    assign present  = (count != '0);
    // An invalidated head drains on its own, without waiting for decode.
    assign pop      = present && (!head.vld || id_rdy);
    assign buf_free = (count < FULL_CNT);

    assign if_vld  = present && head.vld;
    assign if_inst = if_vld ? head.inst : '0;
    assign if_pc   = if_vld ? head.pc   : '0;
    assign if_trd  = if_vld ? head.trd  : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_vld && (mem[i].trd == kill_trd)) begin
                    mem[i].vld <= 1'b0;
                end
            end
            if (push) begin
                mem[wr_ptr] <= '{inst: push_inst, pc: push_pc, trd: push_trd, vld: 1'b1};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch sequencer: one outstanding imem request at a time,
// PC+4 write-back on grant, responses tagged and buffered for decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int BUF_DEPTH = if_fetch_pkg::BUF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TRD_W-1:0]   cur_trd,
    input  logic [PC_W-1:0]    cur_pc,
    input  logic [NUM_TRD-1:0] run_trd,
    input  logic               stall_if,
    input  logic               kill_vld,
    input  logic [TRD_W-1:0]   kill_trd,
    output logic               trd_hold,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvld,
    input  logic [INST_W-1:0]  imem_rdata,
    output logic [NUM_TRD-1:0] pc_wr,
    output logic [PC_W-1:0]    nxt_pc,
    output logic               if_vld,
    output logic [INST_W-1:0]  if_inst,
    output logic [PC_W-1:0]    if_pc,
    output logic [TRD_W-1:0]   if_trd,
    input  logic               id_rdy,
    output logic               fetch_err
);

    fetch_state_e     state;
    logic [TRD_W-1:0] f_trd;
    logic [PC_W-1:0]  f_pc;
    logic             drop;

    logic buf_free;
    logic issue;
    logic kill_f;
    logic gnt_ok;
    logic push;
    logic err_now;

    assign kill_f = kill_vld && (kill_trd == f_trd);
    assign issue  = (state == IDLE) && !stall_if && run_trd[cur_trd] &&
                    !(kill_vld && (kill_trd == cur_trd)) && buf_free;
    assign gnt_ok = (state == REQ) && imem_gnt;
    // A response for a thread killed at any point since issue is discarded.
    assign push    = (state == WAIT) && imem_rvld && !drop && !kill_f;
    assign err_now = (imem_rvld && (state != WAIT)) || (imem_gnt && (state != REQ));

    assign trd_hold  = (state != IDLE) || issue;
    assign imem_req  = (state == REQ);
    assign imem_addr = imem_req ? f_pc : '0;
    assign pc_wr     = gnt_ok ? (NUM_TRD'(1) << f_trd) : '0;
    assign nxt_pc    = gnt_ok ? (f_pc + PC_W'(4)) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            f_trd     <= '0;
            f_pc      <= '0;
            drop      <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            fetch_err <= fetch_err || err_now;
            case (state)
                IDLE: begin
                    if (issue) begin
                        state <= REQ;
                        f_trd <= cur_trd;
                        f_pc  <= cur_pc;
                        drop  <= 1'b0;
                    end
                end
                REQ: begin
                    if (imem_gnt) begin
                        state <= WAIT;
                        if (kill_f) begin
                            drop <= 1'b1;
                        end
                    end else if (kill_f) begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (imem_rvld) begin
                        state <= IDLE;
                    end else if (kill_f) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    if_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_inst (imem_rdata),
        .push_pc   (f_pc),
        .push_trd  (f_trd),
        .kill_vld  (kill_vld),
        .kill_trd  (kill_trd),
        .id_rdy    (id_rdy),
        .if_vld    (if_vld),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .if_trd    (if_trd),
        .buf_free  (buf_free)
    );

endmodule
